parking_occupancy: RTL and testbench
====================================

# parking_occupancy

Occupancy tracker for the parking-lot gate design. It sits directly downstream of the photo-sensor direction detector and consumes its single-cycle Enter/Exit pulses. It maintains the current car count against a fixed capacity and drives full/empty status, registered BCD digits for the HEX display drivers, a saturating lifetime entry total, and sticky error flags for overflow and underflow events.

## Interface
Parameters:
- CAPACITY, default 16: maximum occupancy. Legal range is 1..99, so that two BCD digits suffice.
- TOTAL_W, default 10: width of the lifetime entry counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- Rst  input  1  asynchronous, active-low reset. Low forces every register to its reset value immediately, independent of clk.
- Enter  input  1  one-cycle pulse: a car has entered.
- Exit  input  1  one-cycle pulse: a car has left.
- ClearErr  input  1  synchronous clear of both sticky error flags.
- count  output  7  current occupancy in binary, 0..CAPACITY.
- full  output  1  high when count == CAPACITY.
- empty  output  1  high when count == 0.
- bcd_tens  output  4  tens digit of count, registered.
- bcd_ones  output  4  ones digit of count, registered.
- total  output  TOTAL_W  lifetime accepted entries; saturates at 2^TOTAL_W-1.
- overflow_err  output  1  sticky; set by an Enter rejected while full.
- underflow_err  output  1  sticky; set by an Exit rejected while empty.

## Operation
- The event decode samples Enter and Exit on each rising edge. Pulses longer than one cycle count once per cycle high; the upstream stage guarantees one-cycle pulses.
- **Enter only, count < CAPACITY:** count +1, total +1 (saturating).
- **Enter only, count == CAPACITY:** count unchanged, total unchanged, overflow_err set.
- **Exit only, count > 0:** count -1.
- **Exit only, count == 0:** count unchanged, underflow_err set.
- **Enter and Exit in the same cycle:** net zero, so count is unchanged at any occupancy, including 0 and CAPACITY. total +1 (saturating). No error is set.
- **Neither:** all state holds.
- **full / empty:** registered, updated on the same edge as count from the next-state value. They are never both high, because CAPACITY ≥ 1.
- **BCD conversion:** bcd_tens = count/10 and bcd_ones = count%10, computed from the registered count and captured in a second register stage.
- **total saturation:** at 2^TOTAL_W-1, further accepted entries leave it unchanged and it does not wrap.
- **ClearErr:** clears both error flags on the next edge. If a flag-setting event occurs in the same cycle as ClearErr, set wins and that flag stays 1.
- **Reset:** Rst low mid-operation discards any in-flight event. All outputs take their reset values without waiting for a clock edge.

## Timing
- **Reset values:** count=0, empty=1, full=0, bcd_tens=0, bcd_ones=0, total=0, overflow_err=0, underflow_err=0.
- **Pulse to count/full/empty/total/errors:** a pulse sampled at edge N is reflected immediately after edge N (1-cycle latency).
- **Pulse to bcd_tens/bcd_ones:** reflected after edge N+1 (2-cycle latency). The BCD outputs lag count by exactly one cycle at all times.
- **Back-to-back pulses:** pulses on consecutive cycles are each processed; there is no dead time.
- **Rst release:** the first edge with Rst high processes inputs normally.

## Test plan
- **Reset check:** hold Rst low for 5 cycles, then release -> count=0, empty=1, full=0, BCD digits 0/0, total=0, both error flags 0.
- **Fill to capacity (CAPACITY=3):** 3 Enter pulses -> count 1, 2, 3; full rises one cycle after the third pulse. A 4th Enter -> count stays 3, total stays 3, overflow_err=1.
- **Drain and underflow (CAPACITY=3):** starting at 3, send 4 Exit pulses -> count 2, 1, 0; empty=1; the 4th Exit sets underflow_err with count still 0. Then pulse ClearErr -> both flags return to 0.
- **Simultaneous Enter+Exit (CAPACITY=3):** apply at count=3 and again at count=0 -> count unchanged in both cases, total increments by 1 each time, no error flags set.
- **BCD display (CAPACITY=99):** 12 Enter pulses -> count=12; bcd_tens=1 and bcd_ones=2 exactly one cycle after count reaches 12.
- **Saturation and asynchronous reset (TOTAL_W=3, CAPACITY=99):** interleave 9 Enter/Exit pairs -> total saturates at 7. Then pull Rst low between clock edges -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/parking_occupancy.sv
// Occupancy tracker for the parking-lot gate: counts cars against a fixed capacity,
// drives full/empty and display digits, keeps a saturating entry total and sticky error flags.
module parking_occupancy #(
    parameter int CAPACITY = 16,
    parameter int TOTAL_W  = 10
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               Enter,
    input  logic               Exit,
    input  logic               ClearErr,
    output logic [6:0]         count,
    output logic               full,
    output logic               empty,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones,
    output logic [TOTAL_W-1:0] total,
    output logic               overflow_err,
    output logic               underflow_err
);

    localparam logic [6:0]         CAP       = 7'(CAPACITY);
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
    localparam logic [TOTAL_W-1:0] TOTAL_ONE = TOTAL_W'(1);

    logic [6:0]         r_count;
    logic               r_full;
    logic               r_empty;
    logic [3:0]         r_bcdTens;
    logic [3:0]         r_bcdOnes;
    logic [TOTAL_W-1:0] r_total;
    logic               r_overflowErr;
    logic               r_underflowErr;

    logic [6:0]         w_countNext;
    logic [TOTAL_W-1:0] w_totalNext;
    logic               w_accept;
    logic               w_ovfSet;
    logic               w_unfSet;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;

    // Event decode: simultaneous Enter and Exit nets to zero but still counts as an entry.
    always_comb begin
        w_countNext = r_count;
        w_accept    = 1'b0;
        w_ovfSet    = 1'b0;
        w_unfSet    = 1'b0;
        if (Enter && Exit) begin
            w_accept = 1'b1;
        end else if (Enter) begin
            if (r_count == CAP) begin
                w_ovfSet = 1'b1;
            end else begin
                w_countNext = r_count + 7'd1;
                w_accept    = 1'b1;
            end
        end else if (Exit) begin
            if (r_count == 7'd0) begin
                w_unfSet = 1'b1;
            end else begin
                w_countNext = r_count - 7'd1;
            end
        end
        w_totalNext = (w_accept && (r_total != TOTAL_MAX)) ? (r_total + TOTAL_ONE) : r_total;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_count        <= 7'd0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_total        <= '0;
            r_overflowErr  <= 1'b0;
            r_underflowErr <= 1'b0;
        end else begin
            r_count        <= w_countNext;
            r_full         <= (w_countNext == CAP);
            r_empty        <= (w_countNext == 7'd0);
            r_total        <= w_totalNext;
            r_overflowErr  <= w_ovfSet | (r_overflowErr & ~ClearErr);
            r_underflowErr <= w_unfSet | (r_underflowErr & ~ClearErr);
        end
    end

    // Binary to two-digit BCD by comparing against multiples of ten; count never exceeds 99.
    always_comb begin
        w_tens = 4'd0;
        w_ones = r_count[3:0];
        for (int t = 1; t <= 9; t++) begin
            if (r_count >= 7'(10 * t)) begin
                w_tens = 4'(t);
                w_ones = 4'(r_count - 7'(10 * t));
            end
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_bcdTens <= 4'd0;
            r_bcdOnes <= 4'd0;
        end else begin
            r_bcdTens <= w_tens;
            r_bcdOnes <= w_ones;
        end
    end

    assign count         = r_count;
    assign full          = r_full;
    assign empty         = r_empty;
    assign bcd_tens      = r_bcdTens;
    assign bcd_ones      = r_bcdOnes;
    assign total         = r_total;
    assign overflow_err  = r_overflowErr;
    assign underflow_err = r_underflowErr;

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed bench for parking_occupancy: a CAPACITY=3 instance for fill/drain/error cases
// and a CAPACITY=99, TOTAL_W=3 instance for BCD display, saturation and async reset.
module tb_parking_occupancy;

    logic       clk;
    logic       Rst;

    logic       aEnter, aExit, aClr;
    logic [6:0] aCount;
    logic       aFull, aEmpty, aOvf, aUnf;
    logic [3:0] aTens, aOnes;
    logic [9:0] aTotal;

    logic       bEnter, bExit, bClr;
    logic [6:0] bCount;
    logic       bFull, bEmpty, bOvf, bUnf;
    logic [3:0] bTens, bOnes;
    logic [2:0] bTotal;

    int totalChecks = 0;
    int badChecks   = 0;

    parking_occupancy #(.CAPACITY(3), .TOTAL_W(10)) dutA (
        .clk(clk), .Rst(Rst), .Enter(aEnter), .Exit(aExit), .ClearErr(aClr),
        .count(aCount), .full(aFull), .empty(aEmpty), .bcd_tens(aTens), .bcd_ones(aOnes),
        .total(aTotal), .overflow_err(aOvf), .underflow_err(aUnf)
    );

    parking_occupancy #(.CAPACITY(99), .TOTAL_W(3)) dutB (
        .clk(clk), .Rst(Rst), .Enter(bEnter), .Exit(bExit), .ClearErr(bClr),
        .count(bCount), .full(bFull), .empty(bEmpty), .bcd_tens(bTens), .bcd_ones(bOnes),
        .total(bTotal), .overflow_err(bOvf), .underflow_err(bUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs on the selected instance, starting and ending on a falling edge.
    task automatic applyStimulus(input bit selB, input logic en, input logic ex, input logic clr);
        if (selB) begin
            bEnter = en; bExit = ex; bClr = clr;
        end else begin
            aEnter = en; aExit = ex; aClr = clr;
        end
        @(posedge clk);
        @(negedge clk);
        aEnter = 1'b0; aExit = 1'b0; aClr = 1'b0;
        bEnter = 1'b0; bExit = 1'b0; bClr = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        Rst = 1'b0;
        aEnter = 1'b0; aExit = 1'b0; aClr = 1'b0;
        bEnter = 1'b0; bExit = 1'b0; bClr = 1'b0;

        // Reset held for five cycles.
        repeat (5) @(negedge clk);
        checkOutput("rst_count", aCount, 0);
        checkOutput("rst_empty", aEmpty, 1);
        checkOutput("rst_full", aFull, 0);
        checkOutput("rst_tens", aTens, 0);
        checkOutput("rst_ones", aOnes, 0);
        checkOutput("rst_total", aTotal, 0);
        checkOutput("rst_ovf", aOvf, 0);
        checkOutput("rst_unf", aUnf, 0);
        checkOutput("rstB_empty", bEmpty, 1);
        Rst = 1'b1;

        // Fill the CAPACITY=3 instance; BCD trails count by one cycle.
        applyStimulus(1'b0, 1, 0, 0);
        checkOutput("fill1_count", aCount, 1);
        checkOutput("fill1_empty", aEmpty, 0);
        checkOutput("fill1_onesLag", aOnes, 0);
        applyStimulus(1'b0, 1, 0, 0);
        checkOutput("fill2_count", aCount, 2);
        checkOutput("fill2_full", aFull, 0);
        checkOutput("fill2_ones", aOnes, 1);
        applyStimulus(1'b0, 1, 0, 0);
        checkOutput("fill3_count", aCount, 3);
        checkOutput("fill3_full", aFull, 1);
        checkOutput("fill3_total", aTotal, 3);
        checkOutput("fill3_ones", aOnes, 2);

        // Rejected entry while full.
        applyStimulus(1'b0, 1, 0, 0);
        checkOutput("ovf_count", aCount, 3);
        checkOutput("ovf_total", aTotal, 3);
        checkOutput("ovf_flag", aOvf, 1);
        checkOutput("ovf_unf", aUnf, 0);
        checkOutput("ovf_ones", aOnes, 3);

        // Rejected entry together with ClearErr: the set takes priority.
        applyStimulus(1'b0, 1, 0, 1);
        checkOutput("ovfClr_flag", aOvf, 1);
        checkOutput("ovfClr_total", aTotal, 3);

        // Drain to empty, then underflow.
        applyStimulus(1'b0, 0, 1, 0);
        checkOutput("drain1_count", aCount, 2);
        checkOutput("drain1_full", aFull, 0);
        applyStimulus(1'b0, 0, 1, 0);
        checkOutput("drain2_count", aCount, 1);
        applyStimulus(1'b0, 0, 1, 0);
        checkOutput("drain3_count", aCount, 0);
        checkOutput("drain3_empty", aEmpty, 1);
        applyStimulus(1'b0, 0, 1, 0);
        checkOutput("unf_count", aCount, 0);
        checkOutput("unf_flag", aUnf, 1);
        checkOutput("unf_ovfSticky", aOvf, 1);
        checkOutput("unf_total", aTotal, 3);

        applyStimulus(1'b0, 0, 0, 1);
        checkOutput("clr_ovf", aOvf, 0);
        checkOutput("clr_unf", aUnf, 0);

        // Simultaneous Enter+Exit at empty.
        applyStimulus(1'b0, 1, 1, 0);
        checkOutput("both0_count", aCount, 0);
        checkOutput("both0_total", aTotal, 4);
        checkOutput("both0_empty", aEmpty, 1);
        checkOutput("both0_unf", aUnf, 0);
        checkOutput("both0_ovf", aOvf, 0);

        // Refill and apply simultaneous Enter+Exit at full.
        repeat (3) applyStimulus(1'b0, 1, 0, 0);
        checkOutput("refill_total", aTotal, 7);
        applyStimulus(1'b0, 1, 1, 0);
        checkOutput("both3_count", aCount, 3);
        checkOutput("both3_total", aTotal, 8);
        checkOutput("both3_full", aFull, 1);
        checkOutput("both3_ovf", aOvf, 0);
        checkOutput("both3_unf", aUnf, 0);

        // Saturation of the 3-bit total on the second instance.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 1, 0, 0);
            applyStimulus(1'b1, 0, 1, 0);
            if (i == 6) checkOutput("sat6_total", bTotal, 6);
            if (i == 7) checkOutput("sat7_total", bTotal, 7);
        end
        checkOutput("sat9_total", bTotal, 7);
        checkOutput("sat9_count", bCount, 0);

        // Twelve entries for the BCD display.
        repeat (12) applyStimulus(1'b1, 1, 0, 0);
        checkOutput("bcd_count", bCount, 12);
        checkOutput("bcd_tensLag", bTens, 1);
        checkOutput("bcd_onesLag", bOnes, 1);
        checkOutput("bcd_totalSat", bTotal, 7);
        idleCycle();
        checkOutput("bcd_tens", bTens, 1);
        checkOutput("bcd_ones", bOnes, 2);
        checkOutput("bcd_countHold", bCount, 12);

        // Asynchronous reset between clock edges.
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("arst_countB", bCount, 0);
        checkOutput("arst_totalB", bTotal, 0);
        checkOutput("arst_tensB", bTens, 0);
        checkOutput("arst_onesB", bOnes, 0);
        checkOutput("arst_emptyB", bEmpty, 1);
        checkOutput("arst_countA", aCount, 0);
        checkOutput("arst_fullA", aFull, 0);
        checkOutput("arst_totalA", aTotal, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
